// File: rtl/uart_rx_fifo.sv
// Receive buffer between the UART receiver and the bus side: show-ahead FIFO of
// {perr, data}, sticky overrun, level-threshold and character-timeout interrupts.
module uart_rx_fifo #(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 17360,
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          wr_perr,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_perr,
    input  logic          flush,
    input  logic          ovr_clr,
    input  logic [AW:0]   thresh,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          overrun,
    output logic          thresh_irq,
    output logic          timeout_irq
);

    localparam int TW               = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);

    logic [8:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [TW-1:0] to_cnt;
    logic [TW-1:0] to_cnt_nxt;
    logic [AW:0]   level_nxt;
    logic          push_ok;
    logic          pop_ok;
    logic          ovr_set;

    assign level = wr_ptr - rd_ptr;
    assign empty = (level == '0);
    assign full  = (level == DEPTH_L);

    // Flush overrides everything; a push racing a flush is silently discarded.
    assign pop_ok  = rd_en && !empty && !flush;
    assign push_ok = wr_en && !flush && (!full || pop_ok);
    assign ovr_set = wr_en && !flush && full && !pop_ok;

    assign {rd_perr, rd_data} = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= {wr_perr, wr_data};
        end
    end

    always_comb begin
        level_nxt = '0;
        if (!flush) begin
            level_nxt = level + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
        end
    end

    always_comb begin
        to_cnt_nxt = to_cnt;
        if (flush || push_ok || pop_ok || empty) begin
            to_cnt_nxt = '0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt_nxt = to_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overrun     <= 1'b0;
            to_cnt      <= '0;
            thresh_irq  <= 1'b0;
            timeout_irq <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + (AW + 1)'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + (AW + 1)'(1);
            end

            // A drop in the same cycle as ovr_clr keeps the flag set.
            if (flush)        overrun <= 1'b0;
            else if (ovr_set) overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;

            to_cnt      <= to_cnt_nxt;
            timeout_irq <= (to_cnt_nxt == TO_MAX);
            thresh_irq  <= (thresh != '0) && (level_nxt >= thresh);
        end
    end

endmodule
